decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised RV32I decode stage sitting between fetch and execute.
- Holds the architectural register file, generates immediates and a 4-bit ALU op, and reads both source operands.
- Presents results through a stallable, flushable pipeline register with valid/ready handshakes on both sides.
- Write-back from the last pipeline stage enters through a dedicated write port.

Parameters:
- XLEN, 32, datapath/PC width; immediates sign-extend to XLEN.
- NREG, 32, architectural register count (32 = RV32I, 16 = RV32E); register indices stay 5 bits wide.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_valid  in  1  fetch presents a valid instruction.
- f_pc  in  XLEN  PC of the presented instruction.
- f_instr  in  32  instruction word.
- d_ready  out  1  decode accepts f_* this cycle.
- e_ready  in  1  execute accepts d_* this cycle.
- flush  in  1  discard the held instruction (branch redirect).
- wb_en  in  1  register write enable.
- wb_reg  in  5  write index.
- wb_data  in  XLEN  write data.
- d_valid  out  1  d_* outputs hold a valid decoded instruction.
- d_pc  out  XLEN  registered PC.
- d_dataA, d_dataB  out  XLEN  operand values read from rs1/rs2.
- d_regA, d_regB, d_regD  out  5  rs1, rs2, rd.
- d_imm  out  XLEN  sign-extended immediate.
- d_op  out  4  ALU operation.
- d_funct3  out  3  raw funct3 (branch/load/store sub-type).
- d_w_en  out  1  instruction writes rd.
- d_illegal  out  1  unsupported encoding.

Behaviour:
- Reset (reset=0, asynchronous): d_valid=0; every other d_* output = 0; all registers in the register file = 0.
- Handshake:
  - d_ready = !d_valid || e_ready (combinational).
  - Transfer in when f_valid && d_ready: all d_* load next edge and d_valid=1.
  - When d_ready && !f_valid: d_valid<=0.
  - When !d_ready: d_* hold unchanged.
  - Latency is 1 cycle.
- Flush: d_valid<=0 next edge regardless of f_valid/e_ready; the f_* word presented that cycle is dropped. Flush has priority over load.
- Register file:
  - NREG x XLEN. Write on rising edge when wb_en && wb_reg!=0 && wb_reg<NREG.
  - Register x0 always reads 0.
  - Index >=NREG reads 0.
  - Reads are sampled when the pipeline register loads.
- Immediates by opcode:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits=0.
  - J: JAL, bit0=0.
  - OP: imm=0.
- d_op encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10, BR=11, ILL=15.
  - OP: from funct3 plus funct7[5]; SUB/SRA only when funct7=0100000.
  - OP-IMM: funct7[5] is honoured only for shifts.
  - LOAD/STORE/AUIPC/JAL/JALR: ADD. LUI: PASSB. BRANCH: BR.
- d_w_en: 1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD; else 0. d_regD is forced to 0 when d_w_en=0.
- Illegal: d_illegal=1, d_op=15, d_w_en=0 when any of:
  - unknown opcode;
  - f_instr[1:0]!=11;
  - OP with funct7 not in {0000000, 0100000};
  - any used rs1/rs2/rd >=NREG.
  d_valid stays 1; execute raises the trap.
- Simultaneous write-back and read of the same register in the load cycle: the old value is read unless the optional feature below is compiled in.
- Reset asserted mid-stall: state clears immediately; after release, d_ready=1.

Optional Feature:
- Macro DECODE_WB_BYPASS_EN.
- Defined: when wb_en && wb_reg==rsX && wb_reg!=0 && wb_reg<NREG in the load cycle, d_dataX takes wb_data (write-first).
- Undefined: d_dataX takes the stored value (read-first); the hazard is left to the forwarding unit.

Test Plan:
- Reset, then wb x5=0x0000_1234. Present ADD x7,x5,x0 (0x000283B3), e_ready=1 -> next cycle d_valid=1, d_dataA=0x1234, d_dataB=0, d_op=0, d_regD=7, d_w_en=1.
- Present SW x2,-4(x1) (0xFE20AE23) -> d_imm=0xFFFF_FFFC, d_op=0, d_w_en=0, d_regD=0, d_funct3=010.
- Hold e_ready=0 with d_valid=1, then present a new f_instr -> d_ready=0 and d_* unchanged; raise e_ready -> the new instruction loads next edge.
- flush=1 together with f_valid=1 -> d_valid=0 next cycle; the presented word never appears on d_*.
- Same-cycle wb x3=0xDEAD_BEEF and decode of a read of x3:
  - with DECODE_WB_BYPASS_EN: d_dataA=0xDEADBEEF;
  - without: d_dataA equals the old value (0 after reset).
  wb to x0 -> x0 still reads 0.
- NREG=16: ADDI x20,x0,1 -> d_illegal=1, d_op=15, d_w_en=0. Opcode 0x7F -> d_illegal=1. Apply reset mid-stall -> d_valid=0 asynchronously.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch/decode/execute/write-back signal bundle for decode_stage.
// The master side (fetch, execute, write-back) drives requests; the slave side (decode) returns the decoded instruction.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic [31:0]     f_instr;
  logic            d_ready;
  logic            e_ready;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_reg;
  logic [XLEN-1:0] wb_data;
  logic            d_valid;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_dataA;
  logic [XLEN-1:0] d_dataB;
  logic [4:0]      d_regA;
  logic [4:0]      d_regB;
  logic [4:0]      d_regD;
  logic [XLEN-1:0] d_imm;
  logic [3:0]      d_op;
  logic [2:0]      d_funct3;
  logic            d_w_en;
  logic            d_illegal;

  modport master (
    output f_valid, f_pc, f_instr, e_ready, flush, wb_en, wb_reg, wb_data,
    input  d_ready, d_valid, d_pc, d_dataA, d_dataB, d_regA, d_regB, d_regD,
           d_imm, d_op, d_funct3, d_w_en, d_illegal
  );

  modport slave (
    input  f_valid, f_pc, f_instr, e_ready, flush, wb_en, wb_reg, wb_data,
    output d_ready, d_valid, d_pc, d_dataA, d_dataB, d_regA, d_regB, d_regD,
           d_imm, d_op, d_funct3, d_w_en, d_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: register file, immediate generation, ALU op decode,
// and a stallable/flushable output pipeline register.
// Optional macro DECODE_WB_BYPASS_EN: a write-back to a source register in the
// load cycle is forwarded to the operand (write-first); otherwise read-first.
module decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic           clock,
  input  logic           reset,
  decode_stage_if.slave  bus
);

  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [3:0] ALU_BR    = 4'd11;
  localparam logic [3:0] ALU_ILL   = 4'd15;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data_a;
    logic [XLEN-1:0] data_b;
    logic [XLEN-1:0] imm;
    logic [4:0]      reg_a;
    logic [4:0]      reg_b;
    logic [4:0]      reg_d;
    logic [3:0]      op;
    logic [2:0]      funct3;
    logic            w_en;
    logic            illegal;
  } dec_t;

  logic [XLEN-1:0] rf [NREG];
  logic            valid_q;
  dec_t            dec_q;
  dec_t            nxt;
  logic            d_ready_c;
  logic            wb_hit;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;
  logic [3:0]  op;
  logic        wen;
  logic        unknown;
  logic        bad_f7;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        illegal;

  function automatic logic in_range(input logic [4:0] idx);
    return 6'(idx) < 6'(NREG);
  endfunction

  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign d_ready_c = !valid_q || bus.e_ready;
  assign wb_hit    = bus.wb_en && (bus.wb_reg != 5'd0) && in_range(bus.wb_reg);

  assign instr  = bus.f_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Opcode decode: immediate format, ALU op, write enable and legality.
  always_comb begin
    imm32   = '0;
    op      = ALU_ADD;
    wen     = 1'b0;
    unknown = 1'b0;
    bad_f7  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OPC_OP: begin
        op      = alu_sel(funct3, funct7[5]);
        wen     = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        bad_f7  = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_OP_IMM: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        op      = alu_sel(funct3, (funct3 == 3'd5) && funct7[5]);
        wen     = 1'b1;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_LOAD, OPC_JALR: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        wen     = 1'b1;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OPC_STORE: begin
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        op      = ALU_BR;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_LUI: begin
        imm32  = {instr[31:12], 12'b0};
        op     = ALU_PASSB;
        wen    = 1'b1;
        use_rd = 1'b1;
      end
      OPC_AUIPC: begin
        imm32  = {instr[31:12], 12'b0};
        wen    = 1'b1;
        use_rd = 1'b1;
      end
      OPC_JAL: begin
        imm32  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        wen    = 1'b1;
        use_rd = 1'b1;
      end
      default: unknown = 1'b1;
    endcase

    illegal = unknown || (instr[1:0] != 2'b11) || bad_f7 ||
              (use_rs1 && !in_range(rs1)) ||
              (use_rs2 && !in_range(rs2)) ||
              (use_rd  && !in_range(rd));
    if (illegal) begin
      op  = ALU_ILL;
      wen = 1'b0;
    end
  end

  // Operand read and next pipeline-register contents.
  always_comb begin
    nxt         = '0;
    nxt.pc      = bus.f_pc;
    nxt.imm     = XLEN'($signed(imm32));
    nxt.reg_a   = rs1;
    nxt.reg_b   = rs2;
    nxt.reg_d   = wen ? rd : 5'd0;
    nxt.op      = op;
    nxt.funct3  = funct3;
    nxt.w_en    = wen;
    nxt.illegal = illegal;

    if (rs1 == 5'd0 || !in_range(rs1)) begin
      nxt.data_a = '0;
`ifdef DECODE_WB_BYPASS_EN
    end else if (wb_hit && bus.wb_reg == rs1) begin
      nxt.data_a = bus.wb_data;
`endif
    end else begin
      nxt.data_a = rf[rs1[IDX_W-1:0]];
    end

    if (rs2 == 5'd0 || !in_range(rs2)) begin
      nxt.data_b = '0;
`ifdef DECODE_WB_BYPASS_EN
    end else if (wb_hit && bus.wb_reg == rs2) begin
      nxt.data_b = bus.wb_data;
`endif
    end else begin
      nxt.data_b = rf[rs2[IDX_W-1:0]];
    end
  end

  // Register file write port; x0 and out-of-range indices are never written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[bus.wb_reg[IDX_W-1:0]] <= bus.wb_data;
    end
  end

  // Output pipeline register: flush beats load, load only when ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (d_ready_c) begin
      valid_q <= bus.f_valid;
      if (bus.f_valid) dec_q <= nxt;
    end
  end

  assign bus.d_ready   = d_ready_c;
  assign bus.d_valid   = valid_q;
  assign bus.d_pc      = dec_q.pc;
  assign bus.d_dataA   = dec_q.data_a;
  assign bus.d_dataB   = dec_q.data_b;
  assign bus.d_regA    = dec_q.reg_a;
  assign bus.d_regB    = dec_q.reg_b;
  assign bus.d_regD    = dec_q.reg_d;
  assign bus.d_imm     = dec_q.imm;
  assign bus.d_op      = dec_q.op;
  assign bus.d_funct3  = dec_q.funct3;
  assign bus.d_w_en    = dec_q.w_en;
  assign bus.d_illegal = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a 32-register instance carries the main
// checks, a 16-register instance sees the same stimulus for RV32E legality.
module tb_decode_stage;

  localparam int unsigned XLEN = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [3:0]  op16;
    logic [2:0]  f3;
    logic        wen;
    logic        ill;
    logic        wen16;
    logic        ill16;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] shadow [32];
  exp_t        sb [$];
  int          n_checks;
  int          n_pass;

  decode_stage_if #(.XLEN(XLEN)) bus ();
  decode_stage_if #(.XLEN(XLEN)) bus16 ();

  decode_stage #(.XLEN(XLEN), .NREG(32)) dut (.clock(clock), .reset(reset), .bus(bus));
  decode_stage #(.XLEN(XLEN), .NREG(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16));

  assign bus16.f_valid = bus.f_valid;
  assign bus16.f_pc    = bus.f_pc;
  assign bus16.f_instr = bus.f_instr;
  assign bus16.e_ready = bus.e_ready;
  assign bus16.flush   = bus.flush;
  assign bus16.wb_en   = bus.wb_en;
  assign bus16.wb_reg  = bus.wb_reg;
  assign bus16.wb_data = bus.wb_data;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] sh_rd(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : shadow[r];
  endfunction

  // Output monitor: compare whenever execute takes the decoded instruction.
  always @(negedge clock) begin : mon
    exp_t e;
    if (reset && bus.d_valid && bus.e_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {31'd0, bus.d_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("d_pc", bus.d_pc, e.pc);
        check("d_dataA", bus.d_dataA, e.a);
        check("d_dataB", bus.d_dataB, e.b);
        check("d_regA", 32'(bus.d_regA), 32'(e.ra));
        check("d_regB", 32'(bus.d_regB), 32'(e.rb));
        check("d_regD", 32'(bus.d_regD), 32'(e.rd));
        if (!e.ill) check("d_imm", bus.d_imm, e.imm);
        check("d_op", 32'(bus.d_op), 32'(e.op));
        check("d_funct3", 32'(bus.d_funct3), 32'(e.f3));
        check("d_w_en", 32'(bus.d_w_en), 32'(e.wen));
        check("d_illegal", 32'(bus.d_illegal), 32'(e.ill));
        check("rv32e_valid", 32'(bus16.d_valid), 32'd1);
        check("rv32e_op", 32'(bus16.d_op), 32'(e.op16));
        check("rv32e_w_en", 32'(bus16.d_w_en), 32'(e.wen16));
        check("rv32e_illegal", 32'(bus16.d_illegal), 32'(e.ill16));
      end
    end
  end

  // Present one instruction until accepted; any pending wb_* rides the same cycle.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [3:0] op, input logic [4:0] rd, input logic wen, input logic ill,
                      input logic [3:0] op16, input logic wen16, input logic ill16);
    exp_t       e;
    logic [4:0] r1;
    logic [4:0] r2;
    int         n;
    r1 = instr[19:15];
    r2 = instr[24:20];
    bus.f_instr = instr;
    bus.f_pc    = pc;
    bus.f_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus.d_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.d_ready) begin
      check("send_timeout", 32'(bus.d_ready), 32'd1);
    end else begin
      e.pc  = pc;
      e.a   = sh_rd(r1);
      e.b   = sh_rd(r2);
`ifdef DECODE_WB_BYPASS_EN
      if (bus.wb_en && bus.wb_reg != 5'd0 && bus.wb_reg == r1) e.a = bus.wb_data;
      if (bus.wb_en && bus.wb_reg != 5'd0 && bus.wb_reg == r2) e.b = bus.wb_data;
`endif
      e.ra    = r1;
      e.rb    = r2;
      e.rd    = rd;
      e.imm   = imm;
      e.op    = op;
      e.f3    = instr[14:12];
      e.wen   = wen;
      e.ill   = ill;
      e.op16  = op16;
      e.wen16 = wen16;
      e.ill16 = ill16;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    if (bus.wb_en && bus.wb_reg != 5'd0) shadow[bus.wb_reg] = bus.wb_data;
    bus.f_valid = 1'b0;
    bus.wb_en   = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_reg  = r;
    bus.wb_data = d;
    @(posedge clock);
    #1;
    if (r != 5'd0) shadow[r] = d;
    bus.wb_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b0;
    bus.f_valid = 1'b0;
    bus.f_pc    = '0;
    bus.f_instr = '0;
    bus.e_ready = 1'b0;
    bus.flush   = 1'b0;
    bus.wb_en   = 1'b0;
    bus.wb_reg  = '0;
    bus.wb_data = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_d_valid", 32'(bus.d_valid), 32'd0);
    check("rst_d_ready", 32'(bus.d_ready), 32'd1);
    check("rst_d_pc", bus.d_pc, 32'd0);
    check("rst_d_imm", bus.d_imm, 32'd0);
    check("rst_d_op", 32'(bus.d_op), 32'd0);
    check("rst_d_regD", 32'(bus.d_regD), 32'd0);
    check("rst_d_w_en", 32'(bus.d_w_en), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    wb(5'd5, 32'h0000_1234);
    wb(5'd1, 32'h0000_0100);
    wb(5'd2, 32'h0000_0055);
    wb(5'd0, 32'h0000_0005);
    bus.e_ready = 1'b1;

    send(32'h000283B3, 32'h1000, 32'h0,        4'd0,  5'd7,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0); // ADD x7,x5,x0
    send(32'hFE20AE23, 32'h1004, 32'hFFFFFFFC, 4'd0,  5'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0); // SW x2,-4(x1)
    send(32'hFE208CE3, 32'h1008, 32'hFFFFFFF8, 4'd11, 5'd0,  1'b0, 1'b0, 4'd11, 1'b0, 1'b0); // BEQ x1,x2,-8
    send(32'h80000537, 32'h100C, 32'h80000000, 4'd10, 5'd10, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0); // LUI x10
    send(32'h000010EF, 32'h1010, 32'h00001000, 4'd0,  5'd1,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0); // JAL x1,+4096
    send(32'h4032D493, 32'h1014, 32'h00000403, 4'd7,  5'd9,  1'b1, 1'b0, 4'd7,  1'b1, 1'b0); // SRAI x9,x5,3
    send(32'h00100A13, 32'h1018, 32'h00000001, 4'd0,  5'd20, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1); // ADDI x20,x0,1
    send(32'h0000007F, 32'h101C, 32'h0,        4'd15, 5'd0,  1'b0, 1'b1, 4'd15, 1'b0, 1'b1); // opcode 0x7F
    send(32'h02000033, 32'h1020, 32'h0,        4'd15, 5'd0,  1'b0, 1'b1, 4'd15, 1'b0, 1'b1); // bad funct7
    send(32'h00000233, 32'h1024, 32'h0,        4'd0,  5'd4,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0); // ADD x4,x0,x0
    bus.wb_en   = 1'b1;
    bus.wb_reg  = 5'd3;
    bus.wb_data = 32'hDEAD_BEEF;
    send(32'h00018233, 32'h1028, 32'h0,        4'd0,  5'd4,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0); // ADD x4,x3,x0 + wb x3
    send(32'h00018233, 32'h102C, 32'h0,        4'd0,  5'd4,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0); // re-read x3
    drain();

    // Stall: hold SUB while LUI waits at the input.
    bus.e_ready = 1'b0;
    send(32'h40538433, 32'h1100, 32'h0,        4'd1,  5'd8,  1'b1, 1'b0, 4'd1,  1'b1, 1'b0); // SUB x8,x7,x5
    bus.f_instr = 32'h80000537;
    bus.f_pc    = 32'h1104;
    bus.f_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("stall_d_ready", 32'(bus.d_ready), 32'd0);
      check("stall_d_pc", bus.d_pc, 32'h1100);
      check("stall_d_op", 32'(bus.d_op), 32'd1);
    end
    @(posedge clock);
    #1;
    bus.e_ready = 1'b1;
    send(32'h80000537, 32'h1104, 32'h80000000, 4'd10, 5'd10, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0);
    drain();

    // Flush with an empty register: the presented word is dropped.
    bus.f_instr = 32'h000283B3;
    bus.f_pc    = 32'hBAD0;
    bus.f_valid = 1'b1;
    bus.flush   = 1'b1;
    @(posedge clock);
    #1;
    bus.flush   = 1'b0;
    bus.f_valid = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("flush_d_valid", 32'(bus.d_valid), 32'd0);
    end

    // Flush with a held instruction: both the held and the presented word vanish.
    @(posedge clock);
    #1;
    bus.e_ready = 1'b0;
    send(32'h000283B3, 32'h1200, 32'h0,        4'd0,  5'd7,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0);
    bus.f_instr = 32'hFE20AE23;
    bus.f_pc    = 32'hBAD4;
    bus.f_valid = 1'b1;
    bus.flush   = 1'b1;
    @(posedge clock);
    #1;
    bus.flush   = 1'b0;
    bus.f_valid = 1'b0;
    void'(sb.pop_back());
    bus.e_ready = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("flush_held_d_valid", 32'(bus.d_valid), 32'd0);
    end

    // Reset in the middle of a stall clears state without waiting for a clock edge.
    @(posedge clock);
    #1;
    bus.e_ready = 1'b0;
    send(32'h000283B3, 32'h1300, 32'h0,        4'd0,  5'd7,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_d_valid", 32'(bus.d_valid), 32'd0);
    check("midrst_d_ready", 32'(bus.d_ready), 32'd1);
    check("midrst_d_pc", bus.d_pc, 32'd0);
    check("midrst_rv32e_valid", 32'(bus16.d_valid), 32'd0);
    sb.delete();
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_d_ready", 32'(bus.d_ready), 32'd1);
    bus.e_ready = 1'b1;
    send(32'h000283B3, 32'h1400, 32'h0,        4'd0,  5'd7,  1'b1, 1'b0, 4'd0,  1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
